wb_backing_mem: RTL and testbench

- Wishbone B4 pipelined slave word memory; directly consumes the wb_* master bus driven by the data cache (write-through stores, line fills, dirty evictions).
- Sits between the cache (or a later bus arbiter) and the memory image; the same instance serves simulation and FPGA BRAM.
- Parameterised latency, outstanding-request limit and optional pseudo-random stall injection so cache burst, stall and ack-ordering paths are exercised.

---
 rtl/wb_pkg.sv | 30 +++
 rtl/wb_rsp_pipe.sv | 42 ++++
 rtl/wb_backing_mem.sv | 108 ++++++++++
 tb/tb_wb_backing_mem.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone request/response types and stall-injection LFSR constants
// for the backing memory.
package wb_pkg;

  localparam int unsigned WB_SEL_W = 4;
  localparam int unsigned WB_DAT_W = 32;
  localparam int unsigned WB_ADR_MAX_W = 32;

  localparam logic [7:0] LFSR_SEED = 8'hA5;
  // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef struct packed {
    logic                    we;
    logic [WB_ADR_MAX_W-1:0] adr;
    logic [WB_DAT_W-1:0]     dat;
    logic [WB_SEL_W-1:0]     sel;
  } wb_req_t;

  typedef struct packed {
    logic                ack;
    logic                err;
    logic [WB_DAT_W-1:0] dat;
  } wb_rsp_t;

  function automatic logic [7:0] lfsr_next(input logic [7:0] state);
    return {state[6:0], ^(state & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/wb_rsp_pipe.sv
// Fixed-latency response shift register; an entry is live when ack or err is set.
// The last stage is the bus response and retires on the following edge.
module wb_rsp_pipe
  import wb_pkg::*;
#(
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_ack,
  input  logic                in_err,
  input  logic [WB_DAT_W-1:0] in_dat,
  output logic                out_ack,
  output logic                out_err,
  output logic [WB_DAT_W-1:0] out_dat,
  output logic                retire
);

  wb_rsp_t [LATENCY-1:0] stage_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_q <= '0;
    end else if (flush) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= '{ack: in_ack, err: in_err, dat: in_dat};
      for (int i = 1; i < LATENCY; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  always_comb begin
    out_ack = stage_q[LATENCY-1].ack;
    out_err = stage_q[LATENCY-1].err;
    out_dat = stage_q[LATENCY-1].dat;
    retire  = stage_q[LATENCY-1].ack | stage_q[LATENCY-1].err;
  end

endmodule

// File: rtl/wb_backing_mem.sv
// Wishbone B4 pipelined word memory with fixed response latency, an outstanding
// request cap and optional LFSR stall injection.
module wb_backing_mem
  import wb_pkg::*;
#(
  parameter int unsigned AW              = 12,
  parameter int unsigned MEM_WORDS       = 4096,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          STALL_INJECT    = 1'b0,
  parameter string       MEM_INIT_FILE   = ""
) (
  input  logic          cpu_clock_i,
  input  logic          cpu_reset_i,
  input  logic          wb_cyc_i,
  input  logic          wb_stb_i,
  input  logic          wb_we_i,
  input  logic [AW-1:0] wb_adr_i,
  input  logic [31:0]   wb_dat_i,
  input  logic [3:0]    wb_sel_i,
  output logic          wb_stall_o,
  output logic          wb_ack_o,
  output logic          wb_err_o,
  output logic [31:0]   wb_dat_o
);

  localparam int unsigned IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
    $error("wb_backing_mem: LATENCY must be in 1..8");
  end
  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > LATENCY) begin : g_bad_outstanding
    $error("wb_backing_mem: MAX_OUTSTANDING must be in 1..LATENCY");
  end
  if (MEM_WORDS > (2 ** AW)) begin : g_bad_words
    $error("wb_backing_mem: MEM_WORDS exceeds the address space");
  end

  logic [31:0]      mem [MEM_WORDS];
  logic [CNT_W-1:0] outstanding_q, outstanding_d;
  logic [7:0]       lfsr_q;
  wb_req_t          req;
  logic [IDX_W-1:0] mem_idx;
  logic             accept, in_range, retire, at_cap, inj_stall;
  logic             rsp_ack, rsp_err;
  logic [31:0]      push_dat;

  assign req      = '{we: wb_we_i, adr: WB_ADR_MAX_W'(wb_adr_i), dat: wb_dat_i, sel: wb_sel_i};
  assign mem_idx  = req.adr[IDX_W-1:0];
  assign in_range = req.adr < MEM_WORDS;

  // A response retiring this cycle frees its slot, so the cap sees the net count.
  assign at_cap     = (outstanding_q == CNT_W'(MAX_OUTSTANDING)) && !retire;
  assign inj_stall  = STALL_INJECT && (lfsr_q[1:0] == 2'b11);
  assign wb_stall_o = at_cap | inj_stall;
  assign accept     = wb_cyc_i & wb_stb_i & ~wb_stall_o;

  always_ff @(posedge cpu_clock_i) begin
    if (accept && in_range && req.we) begin
      for (int k = 0; k < WB_SEL_W; k++) begin
        if (req.sel[k]) mem[mem_idx][8*k +: 8] <= req.dat[8*k +: 8];
      end
    end
  end

  assign push_dat = (accept && in_range && !req.we) ? mem[mem_idx] : '0;

  wb_rsp_pipe #(
    .LATENCY(LATENCY)
  ) u_rsp_pipe (
    .clk    (cpu_clock_i),
    .rst    (cpu_reset_i),
    .flush  (~wb_cyc_i),
    .in_ack (accept & in_range),
    .in_err (accept & ~in_range),
    .in_dat (push_dat),
    .out_ack(rsp_ack),
    .out_err(rsp_err),
    .out_dat(wb_dat_o),
    .retire (retire)
  );

  assign wb_ack_o = rsp_ack & wb_cyc_i;
  assign wb_err_o = rsp_err & wb_cyc_i;

  always_comb begin
    outstanding_d = outstanding_q;
    if (!wb_cyc_i) begin
      outstanding_d = '0;
    end else if (accept && !retire) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!accept && retire) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
    if (cpu_reset_i) begin
      outstanding_q <= '0;
      lfsr_q        <= LFSR_SEED;
    end else begin
      outstanding_q <= outstanding_d;
      if (STALL_INJECT) lfsr_q <= lfsr_next(lfsr_q);
    end
  end

endmodule

// File: tb/tb_wb_backing_mem.sv
// Directed bench for wb_backing_mem: four instances cover the default config,
// a single-outstanding slow config, a short memory, and stall injection.
module tb_wb_backing_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [11:0] adr;
  logic [31:0] wdat;
  logic [3:0]  sel;
  int          cur;
  logic [3:0]  cyc_v, stall, ack, err;
  logic [31:0] rdat [4];
  int          n_tests, n_fail;

  always #5 clk = ~clk;

  always_comb begin
    cyc_v = '0;
    for (int i = 0; i < 4; i++) cyc_v[i] = cyc && (cur == i);
  end

  wb_backing_mem #(.AW(12), .MEM_WORDS(4096), .LATENCY(2), .MAX_OUTSTANDING(2),
                   .STALL_INJECT(1'b0), .MEM_INIT_FILE("")) d0 (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .wb_cyc_i(cyc_v[0]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0]), .wb_dat_o(rdat[0]));

  wb_backing_mem #(.AW(12), .MEM_WORDS(4096), .LATENCY(3), .MAX_OUTSTANDING(1),
                   .STALL_INJECT(1'b0), .MEM_INIT_FILE("")) d1 (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .wb_cyc_i(cyc_v[1]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1]), .wb_dat_o(rdat[1]));

  wb_backing_mem #(.AW(12), .MEM_WORDS(2048), .LATENCY(2), .MAX_OUTSTANDING(2),
                   .STALL_INJECT(1'b0), .MEM_INIT_FILE("")) d2 (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .wb_cyc_i(cyc_v[2]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall[2]), .wb_ack_o(ack[2]), .wb_err_o(err[2]), .wb_dat_o(rdat[2]));

  wb_backing_mem #(.AW(12), .MEM_WORDS(4096), .LATENCY(3), .MAX_OUTSTANDING(3),
                   .STALL_INJECT(1'b1), .MEM_INIT_FILE("")) d3 (
    .cpu_clock_i(clk), .cpu_reset_i(rst), .wb_cyc_i(cyc_v[3]), .wb_stb_i(stb),
    .wb_we_i(we), .wb_adr_i(adr), .wb_dat_i(wdat), .wb_sel_i(sel),
    .wb_stall_o(stall[3]), .wb_ack_o(ack[3]), .wb_err_o(err[3]), .wb_dat_o(rdat[3]));

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One request on instance cur: wait out stalls, then follow it to its response.
  task automatic req(input string tag, input logic w, input logic [11:0] a,
                     input logic [31:0] d, input logic [3:0] s, input int lat,
                     input logic exp_err, input logic [31:0] exp_dat);
    int k = 0;
    we = w; adr = a; wdat = d; sel = s; stb = 1'b1;
    while (stall[cur] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({tag, " accept"}, 32'(k < 50), 32'd1);
    @(negedge clk);
    stb = 1'b0;
    for (int i = 1; i < lat; i++) begin
      check({tag, " early"}, {ack[cur], err[cur]}, 32'd0);
      @(negedge clk);
    end
    check({tag, " ack"}, ack[cur], 32'(!exp_err));
    check({tag, " err"}, err[cur], 32'(exp_err));
    if (!w || exp_err) check({tag, " dat"}, rdat[cur], exp_dat);
    @(negedge clk);
    check({tag, " one-shot"}, {ack[cur], err[cur]}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  t4_stall, t4_ack;
    logic [31:0] mdl [8];
    logic [31:0] exp_q [$];
    logic [31:0] exp_w;
    int          acks, issued, stalls, ra, k;
    logic        pending;

    n_tests = 0; n_fail = 0; cur = 0;
    cyc = 0; stb = 0; we = 0; adr = '0; wdat = '0; sel = '0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset ack", ack[0], 32'd0);
    check("reset err", err[0], 32'd0);
    check("reset dat", rdat[0], 32'd0);
    check("reset stall", stall[0], 32'd0);
    check("reset lfsr", d3.lfsr_q, 32'hA5);
    check("reset outstanding", 32'(d3.outstanding_q), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full write, read-back, then a single-lane merge
    cur = 0; cyc = 1'b1;
    req("wr full", 1'b1, 12'h010, 32'hDEADBEEF, 4'b1111, 2, 1'b0, 32'h0);
    req("rd full", 1'b0, 12'h010, 32'h0, 4'b0000, 2, 1'b0, 32'hDEADBEEF);
    req("wr lane2", 1'b1, 12'h010, 32'h11223344, 4'b0100, 2, 1'b0, 32'h0);
    req("rd lane2", 1'b0, 12'h010, 32'h0, 4'b0000, 2, 1'b0, 32'hDE22BEEF);

    // Back-to-back fill burst
    req("pre 20", 1'b1, 12'h020, 32'h12345678, 4'b1111, 2, 1'b0, 32'h0);
    req("pre 21", 1'b1, 12'h021, 32'h9ABCDEF0, 4'b1111, 2, 1'b0, 32'h0);
    we = 1'b0; sel = 4'b0000; stb = 1'b1; adr = 12'h020;
    check("burst stall0", stall[0], 32'd0);
    @(negedge clk);
    check("burst stall1", stall[0], 32'd0);
    check("burst ack early", ack[0], 32'd0);
    adr = 12'h021;
    @(negedge clk);
    check("burst stall2", stall[0], 32'd0);
    check("burst ack A", ack[0], 32'd1);
    check("burst dat A", rdat[0], 32'h12345678);
    stb = 1'b0;
    @(negedge clk);
    check("burst ack B", ack[0], 32'd1);
    check("burst dat B", rdat[0], 32'h9ABCDEF0);
    @(negedge clk);
    check("burst idle", ack[0], 32'd0);
    cyc = 1'b0;

    // One outstanding, latency 3, strobe held for two reads
    cur = 1; cyc = 1'b1;
    req("mo1 pre5", 1'b1, 12'h005, 32'hCAFEF00D, 4'b1111, 3, 1'b0, 32'h0);
    req("mo1 pre6", 1'b1, 12'h006, 32'h0BADC0DE, 4'b1111, 3, 1'b0, 32'h0);
    t4_stall = 8'b0011_0110;
    t4_ack   = 8'b0100_1000;
    acks = 0;
    stb = 1'b1; we = 1'b0; sel = 4'b0000; adr = 12'h005;
    for (int n = 0; n < 8; n++) begin
      check("mo1 stall", stall[1], 32'(t4_stall[n]));
      check("mo1 ack", ack[1], 32'(t4_ack[n]));
      if (ack[1]) begin
        check("mo1 dat", rdat[1], (acks == 0) ? 32'hCAFEF00D : 32'h0BADC0DE);
        acks++;
      end
      if (n == 1) adr = 12'h006;
      if (n == 4) stb = 1'b0;
      @(negedge clk);
    end
    check("mo1 ack count", acks, 32'd2);
    cyc = 1'b0;

    // Out-of-range accesses on the 2048-word instance
    cur = 2; cyc = 1'b1;
    req("oor base", 1'b1, 12'h100, 32'h55AA55AA, 4'b1111, 2, 1'b0, 32'h0);
    req("oor wr", 1'b1, 12'h900, 32'hFFFFFFFF, 4'b1111, 2, 1'b1, 32'h0);
    req("oor rd", 1'b0, 12'h900, 32'h0, 4'b0000, 2, 1'b1, 32'h0);
    check("oor backdoor", d2.mem[256], 32'h55AA55AA);
    req("oor alias rd", 1'b0, 12'h100, 32'h0, 4'b0000, 2, 1'b0, 32'h55AA55AA);
    cyc = 1'b0;

    // Abort one cycle after accept; the write must still land
    cur = 3; cyc = 1'b1;
    we = 1'b1; adr = 12'h030; wdat = 32'h0000ABCD; sel = 4'b1111; stb = 1'b1;
    k = 0;
    while (stall[3] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("abort accept", 32'(k < 50), 32'd1);
    @(negedge clk);
    stb = 1'b0; cyc = 1'b0;
    @(negedge clk);
    check("abort outstanding", 32'(d3.outstanding_q), 32'd0);
    cyc = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("abort no rsp", {ack[3], err[3]}, 32'd0);
    end
    req("post abort rd", 1'b0, 12'h030, 32'h0, 4'b0000, 3, 1'b0, 32'h0000ABCD);

    // Reset with a read in flight
    we = 1'b0; sel = 4'b0000; adr = 12'h030; stb = 1'b1;
    k = 0;
    while (stall[3] && k < 50) begin
      @(negedge clk);
      k++;
    end
    check("rst accept", 32'(k < 50), 32'd1);
    @(negedge clk);
    stb = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst outstanding", 32'(d3.outstanding_q), 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("rst no rsp", {ack[3], err[3]}, 32'd0);
    end
    req("post rst rd", 1'b0, 12'h030, 32'h0, 4'b0000, 3, 1'b0, 32'h0000ABCD);

    // Pipelined reads under stall injection, checked in order against a queue
    for (int i = 0; i < 8; i++) begin
      mdl[i] = 32'h1000_0000 + 32'h0101_0101 * 32'(i);
      req("rnd pre", 1'b1, 12'h040 + 12'(i), mdl[i], 4'b1111, 3, 1'b0, 32'h0);
    end
    issued = 0; acks = 0; stalls = 0; pending = 1'b0; ra = 0;
    we = 1'b0; sel = 4'b0000;
    for (int c = 0; c < 400; c++) begin
      check("rnd err", err[3], 32'd0);
      if (ack[3]) begin
        exp_w = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD0000;
        check("rnd dat", rdat[3], exp_w);
        acks++;
      end
      if (stall[3]) stalls++;
      if (issued < 20) begin
        if (!pending) begin
          ra = $urandom_range(0, 7);
          pending = 1'b1;
        end
        stb = 1'b1;
        adr = 12'h040 + 12'(ra);
        if (!stall[3]) begin
          exp_q.push_back(mdl[ra]);
          issued++;
          pending = 1'b0;
        end
      end else begin
        stb = 1'b0;
      end
      if (issued == 20 && acks == 20) break;
      @(negedge clk);
    end
    stb = 1'b0;
    check("rnd accepts", issued, 32'd20);
    check("rnd acks", acks, 32'd20);
    check("rnd queue empty", exp_q.size(), 32'd0);
    check("rnd stalls seen", 32'(stalls > 0), 32'd1);
    cyc = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
